// File: rtl/program_counter_gen.sv
// Program counter with jump, signed branch, call/return stack, stall and sticky stack error.
// Optional sticky wrap flag output is enabled by defining PC_WRAP_FLAG_EN.
module program_counter_gen #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VEC   = '0,
    parameter int               STEP        = 1,
    parameter int               STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable_increment,
    input  logic                             stall,
    input  logic                             jump,
    input  logic                             branch,
    input  logic [WIDTH-1:0]                 branch_off,
    input  logic                             call,
    input  logic                             ret,
    input  logic [WIDTH-1:0]                 target,
    input  logic                             clear_err,
    output logic [WIDTH-1:0]                 pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             stack_err
`ifdef PC_WRAP_FLAG_EN
   ,output logic                             wrapped
`endif
);

    localparam int               DW        = $clog2(STACK_DEPTH + 1);
    localparam int               AW        = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DW-1:0]    DEPTH_MAX = DW'(STACK_DEPTH);
    localparam logic [DW-1:0]    DEPTH_ONE = DW'(1);
    localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);

    logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_br;
    logic [WIDTH-1:0] ret_addr;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    push_idx;

    logic [WIDTH-1:0] pc_next;
    logic [DW-1:0]    depth_next;
    logic             push_en;
    logic             err_set;
    logic             err_next;

    assign stack_full  = (stack_depth == DEPTH_MAX);
    assign stack_empty = (stack_depth == '0);

    assign pc_inc   = pc + STEP_W;
    assign pc_br    = pc + branch_off;
    assign top_idx  = AW'(stack_depth - DEPTH_ONE);
    assign push_idx = AW'(stack_depth);
    assign ret_addr = stack_mem[top_idx];

    // Priority: stall > ret > call > jump > branch > increment > hold
    always_comb begin
        pc_next    = pc;
        depth_next = stack_depth;
        push_en    = 1'b0;
        err_set    = 1'b0;
        if (!stall) begin
            if (ret) begin
                if (!stack_empty) begin
                    pc_next    = ret_addr;
                    depth_next = stack_depth - DEPTH_ONE;
                end else begin
                    err_set = 1'b1;
                end
            end else if (call) begin
                if (!stack_full) begin
                    pc_next    = target;
                    depth_next = stack_depth + DEPTH_ONE;
                    push_en    = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end else if (jump) begin
                pc_next = target;
            end else if (branch) begin
                pc_next = pc_br;
            end else if (enable_increment) begin
                pc_next = pc_inc;
            end
        end
    end

    // A new error in the same edge as clear_err keeps the flag set
    always_comb begin
        err_next = stack_err;
        if (err_set) begin
            err_next = 1'b1;
        end else if (clear_err) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_VEC;
            stack_depth <= '0;
            stack_err   <= 1'b0;
        end else begin
            pc          <= pc_next;
            stack_depth <= depth_next;
            stack_err   <= err_next;
        end
    end

    // Stack contents are don't-care after reset, so no reset on the storage
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

`ifdef PC_WRAP_FLAG_EN
    logic inc_wrap;
    logic br_wrap;
    logic wrap_set;
    logic wrap_next;

    // Carry/borrow detected by comparing the truncated result against pc
    assign inc_wrap = (pc_inc < pc);
    assign br_wrap  = branch_off[WIDTH-1] ? (pc_br > pc) : (pc_br < pc);

    always_comb begin
        wrap_set = 1'b0;
        if (!stall && !ret && !call && !jump) begin
            if (branch) begin
                wrap_set = br_wrap;
            end else if (enable_increment) begin
                wrap_set = inc_wrap;
            end
        end
    end

    always_comb begin
        wrap_next = wrapped;
        if (wrap_set) begin
            wrap_next = 1'b1;
        end else if (clear_err) begin
            wrap_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrapped <= 1'b0;
        end else begin
            wrapped <= wrap_next;
        end
    end
`endif

endmodule

// File: tb/tb_program_counter_gen.sv
// Self-checking bench for program_counter_gen: directed scenarios plus randomized
// commands checked against a queue-based reference model.
module tb_program_counter_gen;

    localparam int W     = 8;
    localparam int STEP  = 1;
    localparam int DEPTH = 4;
    localparam int MOD   = 256;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable_increment = 1'b0;
    logic         stall = 1'b0;
    logic         jump = 1'b0;
    logic         branch = 1'b0;
    logic [W-1:0] branch_off = '0;
    logic         call = 1'b0;
    logic         ret = 1'b0;
    logic [W-1:0] target = '0;
    logic         clear_err = 1'b0;
    logic [W-1:0] pc;
    logic [2:0]   stack_depth;
    logic         stack_full;
    logic         stack_empty;
    logic         stack_err;
`ifdef PC_WRAP_FLAG_EN
    logic         wrapped;
`endif

    int checks = 0;
    int failures = 0;

    int m_pc;
    int m_err;
    int m_wrap;
    int ras[$];

    program_counter_gen #(
        .WIDTH(W), .RESET_VEC(8'h00), .STEP(STEP), .STACK_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .enable_increment(enable_increment), .stall(stall),
        .jump(jump), .branch(branch), .branch_off(branch_off), .call(call), .ret(ret),
        .target(target), .clear_err(clear_err), .pc(pc), .stack_depth(stack_depth),
        .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
`ifdef PC_WRAP_FLAG_EN
       ,.wrapped(wrapped)
`endif
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pc = 0;
        m_err = 0;
        m_wrap = 0;
        ras.delete();
    endfunction

    // Reference: apply the command table with plain integer arithmetic
    function automatic void model_step();
        int err_new;
        int off;
        int raw;
        err_new = 0;
        if (stall) begin
            if (clear_err) begin
                m_err = 0;
                m_wrap = 0;
            end
            return;
        end
        if (ret) begin
            if (ras.size() > 0) m_pc = ras.pop_back();
            else err_new = 1;
        end else if (call) begin
            if (ras.size() < DEPTH) begin
                ras.push_back((m_pc + STEP) % MOD);
                m_pc = int'(target);
            end else err_new = 1;
        end else if (jump) begin
            m_pc = int'(target);
        end else if (branch) begin
            off = (int'(branch_off) >= MOD / 2) ? int'(branch_off) - MOD : int'(branch_off);
            raw = m_pc + off;
            if (raw < 0 || raw >= MOD) m_wrap = 2;
            m_pc = (raw + MOD) % MOD;
        end else if (enable_increment) begin
            raw = m_pc + STEP;
            if (raw >= MOD) m_wrap = 2;
            m_pc = raw % MOD;
        end
        if (err_new != 0) m_err = 1;
        else if (clear_err) m_err = 0;
        if (m_wrap == 2) m_wrap = 1;
        else if (clear_err) m_wrap = 0;
    endfunction

    task automatic idle();
        enable_increment = 1'b0; stall = 1'b0; jump = 1'b0; branch = 1'b0;
        call = 1'b0; ret = 1'b0; clear_err = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        model_reset();
        #100;
        checks++;
        if (pc !== 8'h00 || stack_depth !== 3'd0 || stack_err !== 1'b0 ||
            stack_empty !== 1'b1 || stack_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: pc=%h depth=%0d err=%b empty=%b full=%b, expected 00/0/0/1/0",
                     pc, stack_depth, stack_err, stack_empty, stack_full);
        end
`ifdef PC_WRAP_FLAG_EN
        checks++;
        if (wrapped !== 1'b0) begin
            failures++;
            $display("FAIL reset_wrapped: got %b expected 0", wrapped);
        end
`endif
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_increment();
        enable_increment = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (pc !== 8'h0A) begin
            failures++;
            $display("FAIL inc_10: pc=%h expected 0a", pc);
        end
        enable_increment = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (pc !== 8'h0A) begin
            failures++;
            $display("FAIL inc_hold: pc=%h expected 0a", pc);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] exp_seq [3];
        exp_seq[0] = 8'hFF; exp_seq[1] = 8'h00; exp_seq[2] = 8'h01;
        jump = 1'b1; target = 8'hFE;
        tick();
        jump = 1'b0;
        enable_increment = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc !== exp_seq[i]) begin
                failures++;
                $display("FAIL wrap_inc%0d: pc=%h expected %h", i, pc, exp_seq[i]);
            end
`ifdef PC_WRAP_FLAG_EN
            checks++;
            if (wrapped !== (i >= 1)) begin
                failures++;
                $display("FAIL wrap_flag%0d: wrapped=%b expected %b", i, wrapped, i >= 1);
            end
`endif
        end
        enable_increment = 1'b0;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    task automatic test_call_ret();
        jump = 1'b1; target = 8'h40;
        tick();
        jump = 1'b0;
        checks++;
        if (pc !== 8'h40) begin
            failures++;
            $display("FAIL jump: pc=%h expected 40", pc);
        end
        call = 1'b1; target = 8'h80;
        tick();
        call = 1'b0;
        checks++;
        if (pc !== 8'h80 || stack_depth !== 3'd1) begin
            failures++;
            $display("FAIL call: pc=%h depth=%0d expected 80/1", pc, stack_depth);
        end
        enable_increment = 1'b1;
        tick(); tick();
        enable_increment = 1'b0;
        checks++;
        if (pc !== 8'h82) begin
            failures++;
            $display("FAIL inc_in_sub: pc=%h expected 82", pc);
        end
        ret = 1'b1;
        tick();
        ret = 1'b0;
        checks++;
        if (pc !== 8'h41 || stack_depth !== 3'd0 || stack_empty !== 1'b1) begin
            failures++;
            $display("FAIL ret: pc=%h depth=%0d empty=%b expected 41/0/1", pc, stack_depth, stack_empty);
        end
    endtask

    task automatic test_stack_limits();
        logic [W-1:0] ret_exp [4];
        ret_exp[0] = 8'h31; ret_exp[1] = 8'h21; ret_exp[2] = 8'h11; ret_exp[3] = 8'h01;
        jump = 1'b1; target = 8'h00;
        tick();
        jump = 1'b0;
        call = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            target = W'(i * 16);
            tick();
            if (i == 4) begin
                checks++;
                if (pc !== 8'h40 || stack_full !== 1'b1 || stack_err !== 1'b0) begin
                    failures++;
                    $display("FAIL call4_full: pc=%h full=%b err=%b expected 40/1/0", pc, stack_full, stack_err);
                end
            end
        end
        call = 1'b0;
        checks++;
        if (pc !== 8'h40 || stack_err !== 1'b1 || stack_depth !== 3'd4) begin
            failures++;
            $display("FAIL overflow: pc=%h err=%b depth=%0d expected 40/1/4", pc, stack_err, stack_depth);
        end
        ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (pc !== ret_exp[i]) begin
                failures++;
                $display("FAIL ret%0d: pc=%h expected %h", i, pc, ret_exp[i]);
            end
        end
        tick();
        ret = 1'b0;
        checks++;
        if (pc !== 8'h01 || stack_err !== 1'b1 || stack_empty !== 1'b1) begin
            failures++;
            $display("FAIL underflow: pc=%h err=%b empty=%b expected 01/1/1", pc, stack_err, stack_empty);
        end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        checks++;
        if (stack_err !== 1'b0 || pc !== 8'h01) begin
            failures++;
            $display("FAIL clear_err: err=%b pc=%h expected 0/01", stack_err, pc);
        end
    endtask

    task automatic test_branch_stall();
        jump = 1'b1; target = 8'h10;
        tick();
        jump = 1'b0;
        branch = 1'b1; branch_off = 8'hFD;
        tick();
        branch = 1'b0;
        checks++;
        if (pc !== 8'h0D) begin
            failures++;
            $display("FAIL branch_neg: pc=%h expected 0d", pc);
        end
        stall = 1'b1; jump = 1'b1; target = 8'h99;
        tick();
        stall = 1'b0; jump = 1'b0;
        checks++;
        if (pc !== 8'h0D) begin
            failures++;
            $display("FAIL stall: pc=%h expected 0d", pc);
        end
        call = 1'b1; ret = 1'b1; target = 8'h55;
        tick();
        call = 1'b0; ret = 1'b0;
        checks++;
        if (pc !== 8'h0D || stack_err !== 1'b1 || stack_depth !== 3'd0) begin
            failures++;
            $display("FAIL call_ret_prio: pc=%h err=%b depth=%0d expected 0d/1/0", pc, stack_err, stack_depth);
        end
        // clear_err honoured during stall, but error beats clear in the same edge
        ret = 1'b1; clear_err = 1'b1;
        tick();
        ret = 1'b0;
        checks++;
        if (stack_err !== 1'b1) begin
            failures++;
            $display("FAIL err_beats_clear: err=%b expected 1", stack_err);
        end
        stall = 1'b1;
        tick();
        stall = 1'b0; clear_err = 1'b0;
        checks++;
        if (stack_err !== 1'b0) begin
            failures++;
            $display("FAIL clear_in_stall: err=%b expected 0", stack_err);
        end
    endtask

    task automatic test_async_reset();
        ret = 1'b1;
        tick();
        ret = 1'b0;
        call = 1'b1; target = 8'h20;
        tick(); tick();
        call = 1'b0;
        checks++;
        if (stack_depth !== 3'd2 || stack_err !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: depth=%0d err=%b expected 2/1", stack_depth, stack_err);
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (pc !== 8'h00 || stack_depth !== 3'd0 || stack_err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: pc=%h depth=%0d err=%b expected 00/0/0", pc, stack_depth, stack_err);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall            = ($urandom_range(0, 9) == 0);
            ret              = ($urandom_range(0, 5) == 0);
            call             = ($urandom_range(0, 4) == 0);
            jump             = ($urandom_range(0, 7) == 0);
            branch           = ($urandom_range(0, 4) == 0);
            enable_increment = ($urandom_range(0, 1) == 1);
            clear_err        = ($urandom_range(0, 15) == 0);
            target           = W'($urandom_range(0, 255));
            branch_off       = W'($urandom_range(0, 255));
            tick();
            checks++;
            if (int'(pc) != m_pc || int'(stack_depth) != ras.size() || int'(stack_err) != m_err ||
                stack_full !== (ras.size() == DEPTH) || stack_empty !== (ras.size() == 0)) begin
                failures++;
                $display("FAIL rand%0d: pc=%h depth=%0d err=%b full=%b empty=%b expected pc=%h depth=%0d err=%0d",
                         i, pc, stack_depth, stack_err, stack_full, stack_empty, m_pc, ras.size(), m_err);
            end
`ifdef PC_WRAP_FLAG_EN
            checks++;
            if (int'(wrapped) != m_wrap) begin
                failures++;
                $display("FAIL rand_wrap%0d: wrapped=%b expected %0d", i, wrapped, m_wrap);
            end
`endif
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_increment();
        test_wrap();
        test_call_ret();
        test_stack_limits();
        test_branch_stall();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_counter_gen.md
Name: program_counter_gen

Overview:
- Parametrised next-generation program counter for the comp101 core.
- Adds the following on top of plain increment/hold/reset:
  - absolute jump
  - signed relative branch
  - call/return through an internal return-address stack
  - stall
  - error flagging
- Feeds instruction-memory address; control inputs come from the decode/control unit.

Parameters:
- WIDTH, 8, PC width in bits; all arithmetic modulo 2^WIDTH.
- RESET_VEC, 0, PC value loaded on reset.
- STEP, 1, increment amount per enabled cycle.
- STACK_DEPTH, 4, return-address stack entries (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable_increment  input  1  advance PC by STEP.
- stall  input  1  freeze all state this cycle.
- jump  input  1  load PC from target.
- branch  input  1  add branch_off to PC.
- branch_off  input  WIDTH  signed two's-complement offset.
- call  input  1  push return address, load PC from target.
- ret  input  1  pop stack into PC.
- target  input  WIDTH  absolute address for jump/call.
- clear_err  input  1  clears stack_err.
- pc  output  WIDTH  current program counter.
- stack_depth  output  $clog2(STACK_DEPTH+1)  occupied entries.
- stack_full  output  1  stack_depth == STACK_DEPTH.
- stack_empty  output  1  stack_depth == 0.
- stack_err  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset asserted (async, any time, including mid-operation):
  - pc = RESET_VEC, stack_depth = 0, stack_err = 0.
  - Stack contents are don't-care.
  - Takes effect without a clock edge. First update occurs on the first rising edge after deassertion.
- All updates are registered. One-cycle latency: a command sampled at edge N is visible on pc after edge N.
- Per-edge priority, highest first:
  1. stall: nothing changes, except clear_err, which is still honoured.
  2. ret:
     - If not empty: pc <= top entry, depth - 1.
     - If empty: pc holds, stack_err <= 1.
  3. call:
     - If not full: push (pc + STEP), pc <= target, depth + 1.
     - If full: pc holds, no push, stack_err <= 1.
  4. jump: pc <= target.
  5. branch: pc <= pc + branch_off (signed, wraps modulo 2^WIDTH).
  6. enable_increment: pc <= pc + STEP (wraps, e.g. FF -> 00 at WIDTH=8).
  7. none asserted: pc holds.
- Simultaneous commands: only the highest-priority one acts; lower ones are ignored. Example: call and ret together means ret acts.
- Push and pop never occur in the same cycle.
- stack_err:
  - Sticky; cleared only by reset or clear_err.
  - If clear_err and a new error occur in the same edge, the error wins (stack_err = 1).
- stack_full, stack_empty: combinational from stack_depth.
- Return address pushed on call is computed modulo 2^WIDTH: a call at pc = FF pushes 00.

Optional Feature:
- Macro: PC_WRAP_FLAG_EN.
- Defined:
  - Adds output port wrapped (1 bit), reset 0.
  - Set sticky on any edge where an increment or branch carries/borrows across the 2^WIDTH boundary (e.g. FF + 1 -> 00, or 01 + (-3) -> FE).
  - Cleared by reset or clear_err.
  - Jump, call and ret never set it.
- Undefined: port absent, no extra logic; all other behaviour identical.

Test Plan:
- Reset low 100 ns, then high; enable_increment = 1 for 10 edges -> pc 00 -> 0A; enable_increment = 0 for 4 edges -> pc holds 0A.
- pc = FE, increment 3 edges -> FF, 00, 01; with PC_WRAP_FLAG_EN, wrapped = 1 after the FF -> 00 edge.
- jump target = 40 -> pc 40; call target = 80 -> pc 80, depth 1; increment 2 -> 82; ret -> pc 41, depth 0, stack_empty = 1.
- 5 consecutive calls (targets 10, 20, 30, 40, 50) from pc 00 -> after 4th: pc 40, stack_full = 1; 5th: pc stays 40, stack_err = 1. Then ret x4 -> pc 31, 21, 11, 01. 5th ret -> pc holds 01, stack_err stays 1. clear_err -> stack_err 0.
- pc = 10, branch with branch_off = FD (-3) -> 0D; stall = 1 with jump target = 99 -> pc stays 0D; call and ret together with empty stack -> ret wins, pc 0D, stack_err = 1.
- After 2 calls, assert reset asynchronously mid-cycle -> pc = 00 and depth = 0 immediately, before the next clk edge; stack_err = 0.
